// File: rtl/gf16_inv_masked_pipe.sv
// ============================================================================
// Module   : gf16_inv_masked_pipe
// Purpose  : 2-share DOM-masked GF(2^4) inversion (v^14), 2-stage valid/ready
//            pipeline. Define GF16INV_PRNG_EN to source randomness from an
//            internal 16-bit LFSR instead of the rnd port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf16_inv_masked_pipe #(
    parameter logic [15:0] PRNG_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic [1:0] z,
    input  logic [1:0] t,
    input  logic [7:0] rnd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] inv_s0,
    output logic [3:0] inv_s1
);

    // Multiply modulo a^4+a+1 by shift-and-add.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
        end
        return acc;
    endfunction

    // Squaring is linear, so it is applied to each share independently.
    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    logic       w_adv1;
    logic       w_adv2;
    logic       w_cap1;
    logic       w_cap2;
    logic [7:0] w_rnd;

    logic       r_v1;
    logic       r_v2;
    logic [3:0] r_s1_dom0, r_s1_dom1, r_s1_crs0, r_s1_crs1;
    logic [3:0] r_s1_sq0, r_s1_sq1;
    logic [3:0] r_s2_dom0, r_s2_dom1, r_s2_crs0, r_s2_crs1;

    logic [3:0] w_v0, w_v1, w_sq0, w_sq1;
    logic [3:0] w_m0, w_m1, w_q0, w_q1;

    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign w_cap1   = in_valid && w_adv1;
    assign w_cap2   = r_v1 && w_adv2;
    assign in_ready = w_adv1;
    assign out_valid = r_v2;

`ifdef GF16INV_PRNG_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic        w_unused_rnd;

    assign w_fb         = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_rnd        = r_lfsr[7:0];
    assign w_unused_rnd = ^rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= PRNG_SEED;
        end else if (w_cap1 || w_cap2) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end
`else
    logic w_unused_seed;

    assign w_rnd         = rnd;
    assign w_unused_seed = ^PRNG_SEED;
`endif

    assign w_v0  = {t[0], z[0], y[0], x[0]};
    assign w_v1  = {t[1], z[1], y[1], x[1]};
    assign w_sq0 = gf_sq(w_v0);
    assign w_sq1 = gf_sq(w_v1);

    // Share compression happens only on registered terms, within one domain.
    assign w_m0 = r_s1_dom0 ^ r_s1_crs0;
    assign w_m1 = r_s1_dom1 ^ r_s1_crs1;
    assign w_q0 = gf_sq(gf_sq(w_m0));
    assign w_q1 = gf_sq(gf_sq(w_m1));

    assign inv_s0 = r_s2_dom0 ^ r_s2_crs0;
    assign inv_s1 = r_s2_dom1 ^ r_s2_crs1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_s1_dom0 <= 4'h0;
            r_s1_dom1 <= 4'h0;
            r_s1_crs0 <= 4'h0;
            r_s1_crs1 <= 4'h0;
            r_s1_sq0  <= 4'h0;
            r_s1_sq1  <= 4'h0;
            r_s2_dom0 <= 4'h0;
            r_s2_dom1 <= 4'h0;
            r_s2_crs0 <= 4'h0;
            r_s2_crs1 <= 4'h0;
        end else begin
            if (w_cap1) begin
                r_v1 <= 1'b1;
            end else if (w_cap2) begin
                r_v1 <= 1'b0;
            end

            if (w_cap2) begin
                r_v2 <= 1'b1;
            end else if (w_adv2) begin
                r_v2 <= 1'b0;
            end

            if (w_cap1) begin
                r_s1_dom0 <= gf_mul(w_v0, w_sq0);
                r_s1_dom1 <= gf_mul(w_v1, w_sq1);
                r_s1_crs0 <= gf_mul(w_v0, w_sq1) ^ w_rnd[3:0];
                r_s1_crs1 <= gf_mul(w_v1, w_sq0) ^ w_rnd[3:0];
                r_s1_sq0  <= w_sq0;
                r_s1_sq1  <= w_sq1;
            end

            if (w_cap2) begin
                r_s2_dom0 <= gf_mul(w_q0, r_s1_sq0);
                r_s2_dom1 <= gf_mul(w_q1, r_s1_sq1);
                r_s2_crs0 <= gf_mul(w_q0, r_s1_sq1) ^ w_rnd[7:4];
                r_s2_crs1 <= gf_mul(w_q1, r_s1_sq0) ^ w_rnd[7:4];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gf16_inv_masked_pipe.sv
// ============================================================================
// Module   : tb_gf16_inv_masked_pipe
// Purpose  : Self-checking bench for gf16_inv_masked_pipe against a
//            field-arithmetic reference (inverse found by search).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf16_inv_masked_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] x, y, z, t;
    logic [7:0] rnd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] inv_s0;
    logic [3:0] inv_s1;

    int total;
    int bad;
    int cyc;

    logic [3:0] cur_v;
    logic [3:0] acc_q[$];
    int         accc_q[$];
    logic [3:0] got_q[$];
    logic [3:0] got0_q[$];
    int         gotc_q[$];

    gf16_inv_masked_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .t         (t),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inv_s0    (inv_s0),
        .inv_s1    (inv_s1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Polynomial product reduced by the field polynomial 0x13.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ ({4'h0, a} << i);
        for (int k = 6; k >= 4; k--)
            if (p[k]) p = p ^ (8'h13 << (k - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] ref_inv(input logic [3:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int w = 1; w < 16; w++)
            if (ref_mul(v, 4'(w)) == 4'h1) r = 4'(w);
        return r;
    endfunction

    task automatic set_in(input logic [3:0] a0, input logic [3:0] a1);
        x = {a1[0], a0[0]};
        y = {a1[1], a0[1]};
        z = {a1[2], a0[2]};
        t = {a1[3], a0[3]};
        cur_v = a0 ^ a1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        accc_q.delete();
        got_q.delete();
        got0_q.delete();
        gotc_q.delete();
    endtask

    // Record handshakes that will complete on the coming edge, then advance.
    task automatic tick();
        #1;
        if (in_valid && in_ready) begin
            acc_q.push_back(cur_v);
            accc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            got_q.push_back(inv_s0 ^ inv_s1);
            got0_q.push_back(inv_s0);
            gotc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rnd = 8'h00;
        set_in(4'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (inv_s0 !== 4'h0) begin bad++; $display("FAIL reset_inv_s0 got=%h want=0", inv_s0); end
        total++; if (inv_s1 !== 4'h0) begin bad++; $display("FAIL reset_inv_s1 got=%h want=0", inv_s1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    // v=2 split 7/5; share0 follows the DOM rule with known randomness.
    task automatic test_directed();
        logic [3:0] a0, a1, s0, s1, m0, q0, r1, r2, exp0;
        clear_q();
        a0 = 4'h7;
        a1 = 4'h5;
`ifdef GF16INV_PRNG_EN
        rnd = 8'hFF;
        r1 = 4'h1;
        r2 = 4'h7;
`else
        rnd = 8'h00;
        r1 = 4'h0;
        r2 = 4'h0;
`endif
        s0 = ref_mul(a0, a0);
        s1 = ref_mul(a1, a1);
        m0 = ref_mul(a0, s0) ^ ref_mul(a0, s1) ^ r1;
        q0 = ref_mul(ref_mul(m0, m0), ref_mul(m0, m0));
        exp0 = ref_mul(q0, s0) ^ ref_mul(q0, s1) ^ r2;
        out_ready = 1'b1;
        set_in(a0, a1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (acc_q.size() != 1) begin bad++; $display("FAIL dir_accept got=%0d want=1", acc_q.size()); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_early_valid got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir_latency got=%b want=1", out_valid); end
        total++; if ((inv_s0 ^ inv_s1) !== 4'h9) begin bad++; $display("FAIL dir_value got=%h want=9", inv_s0 ^ inv_s1); end
        total++; if (inv_s0 !== exp0) begin bad++; $display("FAIL dir_share0 got=%h want=%h", inv_s0, exp0); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals[4];
        logic [3:0] exps[4];
        logic [3:0] sp;
        int n;
        vals = '{4'h0, 4'h1, 4'h3, 4'hF};
        exps = '{4'h0, 4'h1, 4'hE, 4'h8};
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sp = 4'($urandom);
            set_in(sp, sp ^ vals[i]);
            in_valid = 1'b1;
            rnd = 8'($urandom);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready item=%0d got=%b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 4 && n < 20) begin
            rnd = 8'($urandom);
            tick();
            n++;
        end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exps[i]) begin bad++; $display("FAIL b2b_value item=%0d got=%h want=%h", i, got_q[i], exps[i]); end
            total++; if (gotc_q[i] != accc_q[0] + 2 + i) begin bad++; $display("FAIL b2b_timing item=%0d got=%0d want=%0d", i, gotc_q[i], accc_q[0] + 2 + i); end
        end
    endtask

    task automatic test_stall();
        logic [3:0] items[4];
        logic [3:0] snap0, snap1, sp;
        int idx, n;
        clear_q();
        for (int i = 0; i < 4; i++) items[i] = 4'($urandom);
        out_ready = 1'b0;
        idx = 0;
        sp = 4'($urandom);
        set_in(sp, sp ^ items[0]);
        in_valid = 1'b1;
        snap0 = 4'h0;
        snap1 = 4'h0;
        for (int k = 0; k < 7; k++) begin
            rnd = 8'($urandom);
            #1;
            if (k >= 2) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", k, in_ready); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cyc=%0d got=%b want=1", k, out_valid); end
                if (k == 2) begin
                    snap0 = inv_s0;
                    snap1 = inv_s1;
                end else begin
                    total++; if (inv_s0 !== snap0 || inv_s1 !== snap1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h want=%h/%h", k, inv_s0, inv_s1, snap0, snap1); end
                end
            end
            tick();
            if (acc_q.size() > idx) begin
                idx++;
                sp = 4'($urandom);
                if (idx < 4) set_in(sp, sp ^ items[idx]);
                else in_valid = 1'b0;
            end
        end
        total++; if (acc_q.size() != 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", acc_q.size()); end
        out_ready = 1'b1;
        n = 0;
        while ((idx < 4 || got_q.size() < 4) && n < 40) begin
            rnd = 8'($urandom);
            tick();
            if (acc_q.size() > idx) begin
                idx++;
                sp = 4'($urandom);
                if (idx < 4) set_in(sp, sp ^ items[idx]);
                else in_valid = 1'b0;
            end
            n++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_inv(items[i])) begin bad++; $display("FAIL stall_value item=%0d got=%h want=%h", i, got_q[i], ref_inv(items[i])); end
        end
    endtask

    task automatic test_rst_flush();
        clear_q();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_in(4'h3, 4'h9);
        tick();
        set_in(4'h1, 4'h4);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b%b want=10", out_valid, in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        total++; if (inv_s0 !== 4'h0 || inv_s1 !== 4'h0) begin bad++; $display("FAIL flush_shares got=%h/%h want=0/0", inv_s0, inv_s1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL flush_ghost got=%0d want=0", got_q.size()); end
    endtask

    task automatic test_sweep();
        logic [3:0] va[$];
        logic [3:0] sa[$];
        int idx, n;
        bit all_eq;
        clear_q();
        for (int v = 0; v < 16; v++)
            for (int s = 0; s < 16; s++) begin
                va.push_back(4'(v));
                sa.push_back(4'(s));
            end
        idx = 0;
        n = 0;
        set_in(sa[0], sa[0] ^ va[0]);
        in_valid = 1'b1;
        while ((idx < 256 || got_q.size() < 256) && n < 2000) begin
            rnd = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc_q.size() > idx) begin
                idx++;
                if (idx < 256) set_in(sa[idx], sa[idx] ^ va[idx]);
                else in_valid = 1'b0;
            end
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (got_q.size() != 256) begin bad++; $display("FAIL sweep_count got=%0d want=256", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 256; i++) begin
            total++; if (got_q[i] !== ref_inv(va[i])) begin bad++; $display("FAIL sweep_value v=%h s0=%h got=%h want=%h", va[i], sa[i], got_q[i], ref_inv(va[i])); end
        end
        for (int v = 0; v < 16; v++) begin
            if (got0_q.size() >= 16 * v + 16) begin
                all_eq = 1'b1;
                for (int s = 0; s < 16; s++)
                    if (got0_q[16 * v + s] !== ref_inv(4'(v))) all_eq = 1'b0;
                total++; if (all_eq) begin bad++; $display("FAIL sweep_mask v=%h got=share0_unmasked want=masked", v); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        cur_v = 4'h0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rnd = 8'h00;
        x = 2'b00;
        y = 2'b00;
        z = 2'b00;
        t = 2'b00;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_rst_flush();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
